// File: rtl/predictor_accum_if.sv
// Handshake bundle between FMULT product stream and the predictor accumulator.
// O1_ERR exists only when PREDICTOR_ACCUM_ERR_EN is defined.
interface predictor_accum_if #(parameter int W = 16);
  logic         I1_START;
  logic         I1_VALID;
  logic [W-1:0] I16_WX;
  logic         O1_BUSY;
  logic [W-2:0] O15_SEZ;
  logic [W-2:0] O15_SE;
  logic         O1_DONE;
`ifdef PREDICTOR_ACCUM_ERR_EN
  logic         O1_ERR;
`endif

  modport slave (
    input  I1_START, I1_VALID, I16_WX,
`ifdef PREDICTOR_ACCUM_ERR_EN
    output O1_ERR,
`endif
    output O1_BUSY, O15_SEZ, O15_SE, O1_DONE
  );

  modport master (
    output I1_START, I1_VALID, I16_WX,
`ifdef PREDICTOR_ACCUM_ERR_EN
    input  O1_ERR,
`endif
    input  O1_BUSY, O15_SEZ, O15_SE, O1_DONE
  );
endinterface

// File: rtl/predictor_accum.sv
// Time-multiplexed SEZ/SE accumulator fed by one shared FMULT (NB zero terms, then NA pole terms).
// Optional protocol-fault pulse O1_ERR enabled by PREDICTOR_ACCUM_ERR_EN.
module predictor_accum #(
  parameter int NB = 6,
  parameter int NA = 2,
  parameter int W  = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  predictor_accum_if.slave   bus
);
  localparam int CW = $clog2(NB + NA + 1);
  localparam logic [CW-1:0] LAST_B = CW'(NB - 1);
  localparam logic [CW-1:0] LAST_A = CW'(NB + NA - 1);

  typedef enum logic [1:0] {S_IDLE, S_SUM_B, S_SUM_A, S_DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_acc;
  logic [W-2:0]  r_sezi;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [W-2:0]  r_sez;
  logic [W-2:0]  r_se;
  logic          r_err;

  logic [W-1:0]  w_sum;
  logic          w_load;
  logic          w_add;

  assign w_sum  = r_acc + bus.I16_WX;
  assign w_load = bus.I1_VALID && bus.I1_START;
  assign w_add  = bus.I1_VALID && !bus.I1_START;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_sezi  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sez   <= '0;
      r_se    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // A START term always restarts; mid-sequence that is an abort.
      if (w_load) begin
        r_acc   <= bus.I16_WX;
        r_cnt   <= CW'(1);
        r_busy  <= 1'b1;
        r_state <= S_SUM_B;
        r_err   <= (r_state == S_SUM_B) || (r_state == S_SUM_A);
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            r_state <= S_IDLE;
            r_err   <= w_add;
          end
          S_SUM_B: if (w_add) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_B) begin
              r_sezi  <= w_sum[W-1:1];
              r_state <= S_SUM_A;
            end
          end
          S_SUM_A: if (w_add) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
            // Outputs land together with the DONE state so they are visible during it.
            if (r_cnt == LAST_A) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_sez   <= r_sezi;
              r_se    <= w_sum[W-1:1];
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.O1_BUSY = r_busy;
  assign bus.O1_DONE = r_done;
  assign bus.O15_SEZ = r_sez;
  assign bus.O15_SE  = r_se;

`ifdef PREDICTOR_ACCUM_ERR_EN
  assign bus.O1_ERR = r_err;
`else
  logic w_err_unused;
  assign w_err_unused = r_err;
`endif
endmodule

// File: tb/tb_predictor_accum.sv
// Randomized + directed bench for predictor_accum against a term-queue reference model.
module tb_predictor_accum;
  logic clk;
  logic rst;
  predictor_accum_if bus ();

  predictor_accum dut (.CLK(clk), .RESET(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  // reference model: a sequence is just the list of accepted terms
  bit          m_in;
  logic [15:0] m_q[$];
  logic        m_done, m_busy, m_err;
  logic [14:0] m_sez, m_se;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    logic        s_rst, s_v, s_s;
    logic [15:0] s_wx, za, zb;
    s_rst = rst; s_v = bus.I1_VALID; s_s = bus.I1_START; s_wx = bus.I16_WX;
    @(posedge clk);
    #1;
    if (s_rst) begin
      m_in = 0; m_q.delete();
      m_done = 0; m_err = 0; m_sez = '0; m_se = '0;
    end else begin
      m_done = 0;
      m_err  = s_v && (s_s ? m_in : !m_in);
      if (s_v && s_s) begin
        m_q.delete(); m_q.push_back(s_wx); m_in = 1;
      end else if (s_v && m_in) begin
        m_q.push_back(s_wx);
        if (m_q.size() == 8) begin
          za = '0; zb = '0;
          for (int i = 0; i < 8; i++) begin
            if (i < 6) za = za + m_q[i];
            zb = zb + m_q[i];
          end
          m_sez = za[15:1]; m_se = zb[15:1];
          m_done = 1; m_in = 0; m_q.delete();
        end
      end
    end
    m_busy = m_in;
    chk("done", bus.O1_DONE, m_done);
    chk("busy", bus.O1_BUSY, m_busy);
    chk("sez", bus.O15_SEZ, m_sez);
    chk("se", bus.O15_SE, m_se);
`ifdef PREDICTOR_ACCUM_ERR_EN
    chk("err", bus.O1_ERR, m_err);
    if (bus.O1_ERR) err_cnt++;
`endif
    if (bus.O1_DONE) begin done_cnt++; done_cyc = cyc; end
    cyc++;
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] wx);
    bus.I1_VALID = v; bus.I1_START = s; bus.I16_WX = wx;
    tick();
  endtask

  task automatic send_seq(input logic [15:0] b, input logic [15:0] a,
                          input int stall_after, input int stall_len);
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k == 0, (k < 6) ? b : a);
      if (k == stall_after)
        for (int j = 0; j < stall_len; j++) drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
    end
  endtask

  // term 0 is presented in cycle 1; DONE observed after the edge of tick done_cyc
  function automatic int lat();
    return done_cyc - t0 + 2;
  endfunction

  int n0;

  initial begin
    rst = 1'b1;
    bus.I1_VALID = 0; bus.I1_START = 0; bus.I16_WX = '0;
    tick(); tick();
    chk("rst_sez", bus.O15_SEZ, 15'h0);
    chk("rst_busy", bus.O1_BUSY, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0);

    // basic sums
    n0 = done_cnt;
    send_seq(16'h0010, 16'h0020, -1, 0);
    chk("bas_lat", lat(), 9);
    chk("bas_n", done_cnt - n0, 1);
    chk("bas_sez", bus.O15_SEZ, 15'h0030);
    chk("bas_se", bus.O15_SE, 15'h0050);
    // back-to-back: next START lands in the DONE cycle
    send_seq(16'hFFFF, 16'hFFFF, -1, 0);
    chk("neg_lat", lat(), 9);
    chk("neg_sez", bus.O15_SEZ, 15'h7FFD);
    chk("neg_se", bus.O15_SE, 15'h7FFC);
    send_seq(16'h4000, 16'h4000, -1, 0);
    chk("wrap_sez", bus.O15_SEZ, 15'h4000);
    chk("wrap_se", bus.O15_SE, 15'h0000);
    drive(1'b0, 1'b0, 16'h0);

    // stall of 3 after term 3
    send_seq(16'h0010, 16'h0020, 3, 3);
    chk("stall_lat", lat(), 12);
    chk("stall_sez", bus.O15_SEZ, 15'h0030);
    chk("stall_se", bus.O15_SE, 15'h0050);
    drive(1'b0, 1'b0, 16'h0);

    // abort on term 4, then a fresh sequence of ones
    n0 = done_cnt;
    err_cnt = 0;
    for (int k = 0; k < 4; k++) drive(1'b1, k == 0, 16'h0010);
    send_seq(16'h0001, 16'h0001, -1, 0);
    drive(1'b0, 1'b0, 16'h0);
    chk("abort_n", done_cnt - n0, 1);
    chk("abort_sez", bus.O15_SEZ, 15'h0003);
    chk("abort_se", bus.O15_SE, 15'h0004);
`ifdef PREDICTOR_ACCUM_ERR_EN
    chk("abort_err", err_cnt, 1);
`endif

    // reset after term 5
    n0 = done_cnt;
    for (int k = 0; k < 6; k++) drive(1'b1, k == 0, 16'h0123);
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0123);
    rst = 1'b0;
    chk("mrst_sez", bus.O15_SEZ, 15'h0);
    chk("mrst_se", bus.O15_SE, 15'h0);
    chk("mrst_busy", bus.O1_BUSY, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 16'h0777);
    chk("mrst_n", done_cnt - n0, 0);
    send_seq(16'h0010, 16'h0020, -1, 0);
    chk("mrst_lat", lat(), 9);
    chk("mrst_sez2", bus.O15_SEZ, 15'h0030);
    chk("mrst_se2", bus.O15_SE, 15'h0050);

    // random traffic
    n0 = done_cnt;
    for (int i = 0; i < 600; i++) begin
      logic v;
      rst = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 3) != 0);
      drive(v, v ? ($urandom_range(0, 11) == 0) : 1'($urandom_range(0, 1)), 16'($urandom));
    end
    rst = 1'b0;
    chk("rand_done_seen", done_cnt > n0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
